// File: rtl/region_signal_gen.sv
// ---------------------------------------------------------------------------
// region_signal_gen
//
// Purpose:
//   Checks the current VGA pixel coordinate against NUM_REGIONS programmable
//   rectangles (bat, stumps, ball zones) and raises a registered hit for each
//   region. A strike request is edge-detected and stretched over HOLD_FRAMES
//   frames, so the strike feedback stays on screen for longer than one frame.
//   'signal' combines the strike indication with all region hits. It feeds the
//   colour/collision logic.
//
// Ports:
//   clock         in   system clock, all state changes on the rising edge
//   reset         in   synchronous, active-high reset
//   xpixel        in   current pixel column  [X_WIDTH]
//   ypixel        in   current pixel row     [Y_WIDTH]
//   pixel_valid   in   coordinate is inside the active display area
//   frame_start   in   one-cycle pulse at the start of each frame
//   strike        in   level strike request from the game logic
//   cfg_we        in   region configuration write strobe
//   cfg_idx       in   index of the region to write [IDX_WIDTH]
//   cfg_xmin/xmax in   inclusive x bounds [X_WIDTH]
//   cfg_ymin/ymax in   inclusive y bounds [Y_WIDTH]
//   cfg_enable    in   region enable
//   region_hit    out  registered hit for each region [NUM_REGIONS]
//   strike_active out  registered strike indication (level OR hold)
//   signal        out  registered OR of strike_active and all region hits
// ---------------------------------------------------------------------------
module region_signal_gen #(
    parameter int NUM_REGIONS = 4,
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 9,
    parameter int HOLD_FRAMES = 8,
    parameter int IDX_WIDTH   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [X_WIDTH-1:0]     xpixel,
    input  logic [Y_WIDTH-1:0]     ypixel,
    input  logic                   pixel_valid,
    input  logic                   frame_start,
    input  logic                   strike,
    input  logic                   cfg_we,
    input  logic [IDX_WIDTH-1:0]   cfg_idx,
    input  logic [X_WIDTH-1:0]     cfg_xmin,
    input  logic [X_WIDTH-1:0]     cfg_xmax,
    input  logic [Y_WIDTH-1:0]     cfg_ymin,
    input  logic [Y_WIDTH-1:0]     cfg_ymax,
    input  logic                   cfg_enable,
    output logic [NUM_REGIONS-1:0] region_hit,
    output logic                   strike_active,
    output logic                   signal
);

    typedef struct packed {
        logic [X_WIDTH-1:0] xmin;
        logic [X_WIDTH-1:0] xmax;
        logic [Y_WIDTH-1:0] ymin;
        logic [Y_WIDTH-1:0] ymax;
        logic               enable;
    } region_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_CNT  = 8'(HOLD_FRAMES);
    localparam bit         STRETCH   = (HOLD_FRAMES > 0);

    // Region 0 comes out of reset as the default bat zone. The others come out
    // of reset cleared and disabled.
    localparam region_t REGION0_DEFAULT = '{
        xmin:   X_WIDTH'(4),
        xmax:   X_WIDTH'(7),
        ymin:   Y_WIDTH'(175),
        ymax:   Y_WIDTH'(230),
        enable: 1'b1
    };

    region_t                r_region [NUM_REGIONS];
    region_t                w_cfg;
    logic [NUM_REGIONS-1:0] w_hit_next;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_next;
    logic                   r_strike_q;
    logic                   w_rise;
    logic                   w_strike_active_next;

    logic [NUM_REGIONS-1:0] r_region_hit;
    logic                   r_strike_active;
    logic                   r_signal;

    assign w_cfg = '{
        xmin:   cfg_xmin,
        xmax:   cfg_xmax,
        ymin:   cfg_ymin,
        ymax:   cfg_ymax,
        enable: cfg_enable
    };

    // -----------------------------------------------------------------------
    // Region configuration storage
    // -----------------------------------------------------------------------
    // NOTE: this register array is reset on purpose. Region 0 must be usable
    // straight after reset, so the array cannot power up with random bounds.
    // An index at or above NUM_REGIONS matches no entry, so that write is
    // dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                r_region[i] <= '0;
            end
            r_region[0] <= REGION0_DEFAULT;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (int'(cfg_idx) == i) begin
                    r_region[i] <= w_cfg;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Region compare (unsigned, inclusive). The compare uses the stored
    // bounds, so a pixel sampled on the same edge as a config write still sees
    // the old bounds. An inverted rectangle can never pass both comparisons.
    // -----------------------------------------------------------------------
    // NOTE: each signal written in always_comb gets a default value first.
    // This ensures no path leaves it unassigned, so no latch is inferred.
    always_comb begin
        w_hit_next = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_hit_next[i] = r_region[i].enable & pixel_valid
                          & (xpixel >= r_region[i].xmin) & (xpixel <= r_region[i].xmax)
                          & (ypixel >= r_region[i].ymin) & (ypixel <= r_region[i].ymax);
        end
    end

    // -----------------------------------------------------------------------
    // Strike stretch FSM: next-state logic
    // -----------------------------------------------------------------------
    assign w_rise = strike & ~r_strike_q;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && STRETCH) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = HOLD_CNT;
                end
            end
            ST_HOLD: begin
                // A retrigger takes priority over a frame_start on the same
                // edge. The count reloads and does not decrement.
                if (w_rise) begin
                    w_cnt_next = HOLD_CNT;
                end else if (frame_start) begin
                    w_cnt_next = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // The registered outputs are built from next-state values. This gives
    // strike_active and signal the same single-cycle latency as region_hit.
    assign w_strike_active_next = strike | (w_state_next == ST_HOLD);

    // -----------------------------------------------------------------------
    // FSM state and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from values taken before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_strike_q      <= 1'b0;
            r_region_hit    <= '0;
            r_strike_active <= 1'b0;
            r_signal        <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_strike_q      <= strike;
            r_region_hit    <= w_hit_next;
            r_strike_active <= w_strike_active_next;
            r_signal        <= w_strike_active_next | (|w_hit_next);
        end
    end

    assign region_hit    = r_region_hit;
    assign strike_active = r_strike_active;
    assign signal        = r_signal;

endmodule
